w_load_sched: RTL and testbench
===============================

// Module: w_load_sched
// PURPOSE
// Sequences the W-weight load for the LSTM systolic array. For each gate selected by a command
// mask, it clears and starts the weight address generator and streams the generated temp_buff
// addresses into the selected gate's W_i DPR bank. It owns the temp_buff read port during a
// load and grants that port to the host reader only when idle or in error.
// PARAMETERS
// FEATURE_BITS     4    AG feature counter width; addresses are 2*FEATURE_BITS wide
// NGATES           4    number of LSTM gates (i,f,g,o), one DPR bank group per gate
// GATE_BITS        2    clog2(NGATES)
// MAX_PASS_CYCLES  255  RUN cycles allowed per pass before timeout (8-bit counter)
// PORTS
// sys_clk        in   1               systolic array clock
// reset_n        in   1               async active-low reset
// cmd_valid      in   1               load command valid
// cmd_ready      out  1               high only in IDLE
// cmd_gate_mask  in   NGATES          gates to load; bit k = gate k
// abort          in   1               abandon the current load; return to IDLE
// ag_rst_n       out  1               registered active-low clear to the AG
// ag_start       out  1               AG count enable
// ag_done        in   1               AG sticky done
// ag_addr        in   2*FEATURE_BITS  AG temp_buff address
// ag_cs          in   FEATURE_BITS-1  AG chip select within the gate's W_i bank
// buff_rd_en     out  1               temp_buff read enable
// buff_rd_addr   out  2*FEATURE_BITS  temp_buff read address
// dpr_we         out  1               W DPR write enable (1 cycle after buff_rd_en)
// dpr_cs         out  FEATURE_BITS-1  ag_cs delayed 1 cycle
// dpr_wr_addr    out  2*FEATURE_BITS  ag_addr delayed 1 cycle
// gate_sel       out  GATE_BITS       gate bank currently written
// host_req       in   1               host temp_buff read request
// host_addr      in   2*FEATURE_BITS  host read address
// host_gnt       out  1               host owns the read port this cycle
// busy           out  1               state != IDLE
// load_done      out  1               1-cycle pulse when all masked gates are loaded
// err            out  1               sticky pass timeout; cleared by abort or reset
// BEHAVIOUR
// - Reset values: state=IDLE, mask=0, gate_sel=0, ag_rst_n=1, pass_cnt=0, err=0.
//   All other outputs are 0 at reset.
// - FSM states: IDLE, CLR, RUN, NEXT, FIN, ERR.
// - IDLE: cmd_valid&&cmd_ready latches the mask.
//   - mask==0: go to FIN.
//   - otherwise: gate_sel = lowest set bit; go to CLR.
// - CLR (1 cycle): ag_rst_n=0, ag_start=0, pass_cnt=0; go to RUN.
// - RUN: ag_start=1.
//   - While !ag_done: buff_rd_en=1, buff_rd_addr=ag_addr, pass_cnt increments.
//   - ag_done=1: no read that cycle; clear mask[gate_sel]; go to NEXT.
//   - pass_cnt==MAX_PASS_CYCLES-1 with ag_done=0: go to ERR, set err=1.
// - NEXT (1 cycle): if the remaining mask != 0, gate_sel = lowest set bit and go to CLR;
//   else go to FIN.
// - FIN (1 cycle): load_done=1; go to IDLE.
// - ERR: ag_rst_n held 0, ag_start=0; stays until abort.
// - abort takes priority in any non-IDLE state:
//   - next state IDLE, mask cleared, err cleared.
//   - ag_rst_n=0 for exactly 1 cycle; no load_done.
//   - abort in IDLE is ignored.
// - Write pipeline: dpr_we, dpr_cs and dpr_wr_addr are buff_rd_en, ag_cs and ag_addr (load
//   reads only) delayed by one flop, matching the 1-cycle temp_buff read latency.
//   - gate_sel is stable through the last write of a pass, because NEXT follows RUN.
//   - abort squashes the pending write: dpr_we=0 in the following cycle.
// - Port arbitration: host_gnt = host_req && (state==IDLE || state==ERR).
//   - When granted: buff_rd_en=1, buff_rd_addr=host_addr in the same cycle.
//   - Host reads never produce dpr_we.
//   - A command accepted in the same cycle as a host grant is legal; CLR does not read.
// - ag_rst_n comes from a flop: it is low in the cycle the FSM is in CLR or ERR, or in the
//   cycle after an abort.
// - AG at M=9, P=4, GAMMA=3: 108 reads per pass; each pass occupies CLR(1)+RUN(109)+NEXT(1).
// TESTING
// - mask=4'b0001, AG 9/4/3 -> 108 dpr_we cycles with gate_sel=0, addresses in AG order;
//   load_done pulses once; cmd_ready returns to 1.
// - mask=4'b1010 -> gate_sel goes 1 then 3; 216 writes total; ag_rst_n low exactly 2 cycles;
//   one load_done.
// - mask=4'b0000 -> load_done 2 cycles after acceptance; no ag_start, no buff_rd_en.
// - host_req held during a mask=4'b1111 load -> host_gnt=0 from CLR until IDLE;
//   granted in the first IDLE cycle with buff_rd_addr=host_addr and no dpr_we.
// - ag_done tied 0 -> err=1 after 255 RUN cycles; ag_rst_n held low; host granted;
//   abort -> IDLE, err=0.
// - abort at RUN cycle 50 -> no dpr_we from 2 cycles later onward; ag_rst_n low 1 cycle;
//   no load_done; a new command is accepted next.

Source files
------------

// File: rtl/w_load_sched.sv
// rtl/w_load_sched.sv - W-weight load sequencer for the LSTM systolic array
//
// Purpose: for every gate selected in a command mask, clears and starts the
// weight address generator (AG) and streams its temp_buff addresses into the
// selected gate's W_i DPR bank. The temp_buff read port belongs to the load
// while one is in flight; the host may use it only in IDLE or ERR.
//
// Ports:
//   sys_clk, reset_n          clock, async active-low reset
//   i_cmd_valid/o_cmd_ready   load command handshake (ready only in IDLE)
//   i_cmd_gate_mask           gates to load, bit k = gate k
//   i_abort                   abandon the current load, back to IDLE
//   o_ag_rst_n, o_ag_start    AG clear (registered) and count enable
//   i_ag_done/addr/cs         AG sticky done, temp_buff address, chip select
//   o_buff_rd_en/addr         temp_buff read port
//   o_dpr_we/cs/wr_addr       W DPR write port, one cycle behind the read
//   o_gate_sel                gate bank currently written
//   i_host_req/addr, o_host_gnt  host access to the temp_buff read port
//   o_busy, o_load_done, o_err   status: not idle, all gates loaded, timeout

module w_load_sched #(
  parameter int FEATURE_BITS    = 4,
  parameter int NGATES          = 4,
  parameter int GATE_BITS       = 2,
  parameter int MAX_PASS_CYCLES = 255
) (
  input  logic                      sys_clk,
  input  logic                      reset_n,
  input  logic                      i_cmd_valid,
  output logic                      o_cmd_ready,
  input  logic [NGATES-1:0]         i_cmd_gate_mask,
  input  logic                      i_abort,
  output logic                      o_ag_rst_n,
  output logic                      o_ag_start,
  input  logic                      i_ag_done,
  input  logic [2*FEATURE_BITS-1:0] i_ag_addr,
  input  logic [FEATURE_BITS-2:0]   i_ag_cs,
  output logic                      o_buff_rd_en,
  output logic [2*FEATURE_BITS-1:0] o_buff_rd_addr,
  output logic                      o_dpr_we,
  output logic [FEATURE_BITS-2:0]   o_dpr_cs,
  output logic [2*FEATURE_BITS-1:0] o_dpr_wr_addr,
  output logic [GATE_BITS-1:0]      o_gate_sel,
  input  logic                      i_host_req,
  input  logic [2*FEATURE_BITS-1:0] i_host_addr,
  output logic                      o_host_gnt,
  output logic                      o_busy,
  output logic                      o_load_done,
  output logic                      o_err
);

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_RUN, S_NEXT, S_FIN, S_ERR} state_t;

  localparam logic [7:0] LP_PASS_LAST = 8'(MAX_PASS_CYCLES - 1);

  state_t                    r_state;
  logic [NGATES-1:0]         r_mask;
  logic [GATE_BITS-1:0]      r_gate_sel;
  logic                      r_ag_rst_n;
  logic                      r_ag_start;
  logic [7:0]                r_pass_cnt;
  logic                      r_err;
  logic                      r_load_done;
  logic                      r_dpr_we;
  logic [FEATURE_BITS-2:0]   r_dpr_cs;
  logic [2*FEATURE_BITS-1:0] r_dpr_wr_addr;

  logic w_idle;
  logic w_abort;
  logic w_load_rd;
  logic w_host_gnt;

  // Lowest set bit wins: scanning downward lets the lowest index overwrite.
  function automatic logic [GATE_BITS-1:0] f_lowest(input logic [NGATES-1:0] mask);
    f_lowest = '0;
    for (int i = NGATES - 1; i >= 0; i--) begin
      if (mask[i]) f_lowest = GATE_BITS'(i);
    end
  endfunction

  assign w_idle     = (r_state == S_IDLE);
  assign w_abort    = i_abort && !w_idle;
  assign w_load_rd  = (r_state == S_RUN) && !i_ag_done;
  assign w_host_gnt = i_host_req && (w_idle || (r_state == S_ERR));

  // States that own the port never grant the host, so the two read sources
  // are mutually exclusive.
  assign o_buff_rd_en   = w_host_gnt || w_load_rd;
  assign o_buff_rd_addr = w_host_gnt ? i_host_addr :
                          w_load_rd  ? i_ag_addr   : '0;

  assign o_host_gnt    = w_host_gnt;
  assign o_cmd_ready   = w_idle;
  assign o_busy        = !w_idle;
  assign o_ag_rst_n    = r_ag_rst_n;
  assign o_ag_start    = r_ag_start;
  assign o_gate_sel    = r_gate_sel;
  assign o_err         = r_err;
  assign o_load_done   = r_load_done;
  assign o_dpr_we      = r_dpr_we;
  assign o_dpr_cs      = r_dpr_cs;
  assign o_dpr_wr_addr = r_dpr_wr_addr;

  // ag_rst_n / ag_start are set from the state being entered, so they line
  // up with CLR/ERR and RUN without a combinational path to the AG.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_mask        <= '0;
      r_gate_sel    <= '0;
      r_ag_rst_n    <= 1'b1;
      r_ag_start    <= 1'b0;
      r_pass_cnt    <= '0;
      r_err         <= 1'b0;
      r_load_done   <= 1'b0;
      r_dpr_we      <= 1'b0;
      r_dpr_cs      <= '0;
      r_dpr_wr_addr <= '0;
    end else begin
      r_load_done <= 1'b0;
      r_ag_rst_n  <= 1'b1;
      r_ag_start  <= 1'b0;

      // temp_buff has one cycle of read latency; abort squashes the
      // write still in the pipe.
      r_dpr_we <= w_load_rd && !w_abort;
      if (w_load_rd) begin
        r_dpr_cs      <= i_ag_cs;
        r_dpr_wr_addr <= i_ag_addr;
      end

      if (w_abort) begin
        r_state    <= S_IDLE;
        r_mask     <= '0;
        r_err      <= 1'b0;
        r_ag_rst_n <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_cmd_valid) begin
              r_mask <= i_cmd_gate_mask;
              if (i_cmd_gate_mask == '0) begin
                r_state <= S_FIN;
              end else begin
                r_gate_sel <= f_lowest(i_cmd_gate_mask);
                r_pass_cnt <= '0;
                r_ag_rst_n <= 1'b0;
                r_state    <= S_CLR;
              end
            end
          end
          S_CLR: begin
            r_pass_cnt <= '0;
            r_ag_start <= 1'b1;
            r_state    <= S_RUN;
          end
          S_RUN: begin
            if (i_ag_done) begin
              r_mask[r_gate_sel] <= 1'b0;
              r_state            <= S_NEXT;
            end else if (r_pass_cnt == LP_PASS_LAST) begin
              r_err      <= 1'b1;
              r_ag_rst_n <= 1'b0;
              r_state    <= S_ERR;
            end else begin
              r_pass_cnt <= r_pass_cnt + 8'd1;
              r_ag_start <= 1'b1;
            end
          end
          S_NEXT: begin
            if (r_mask != '0) begin
              r_gate_sel <= f_lowest(r_mask);
              r_pass_cnt <= '0;
              r_ag_rst_n <= 1'b0;
              r_state    <= S_CLR;
            end else begin
              r_state <= S_FIN;
            end
          end
          S_FIN: begin
            r_load_done <= 1'b1;
            r_state     <= S_IDLE;
          end
          S_ERR: begin
            r_ag_rst_n <= 1'b0;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_w_load_sched.sv
// tb/tb_w_load_sched.sv - scoreboard bench for w_load_sched

module tb_w_load_sched;

  localparam int MAXP = 255;

  logic       sys_clk = 1'b0;
  logic       reset_n;
  logic       cmd_valid, cmd_ready, abort;
  logic [3:0] cmd_gate_mask;
  logic       ag_rst_n, ag_start, ag_done;
  logic [7:0] ag_addr;
  logic [2:0] ag_cs;
  logic       buff_rd_en, dpr_we, host_req, host_gnt, busy, load_done, err;
  logic [7:0] buff_rd_addr, dpr_wr_addr, host_addr;
  logic [2:0] dpr_cs;
  logic [1:0] gate_sel;

  w_load_sched dut (
    .sys_clk(sys_clk), .reset_n(reset_n),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_gate_mask(cmd_gate_mask),
    .i_abort(abort), .o_ag_rst_n(ag_rst_n), .o_ag_start(ag_start),
    .i_ag_done(ag_done), .i_ag_addr(ag_addr), .i_ag_cs(ag_cs),
    .o_buff_rd_en(buff_rd_en), .o_buff_rd_addr(buff_rd_addr),
    .o_dpr_we(dpr_we), .o_dpr_cs(dpr_cs), .o_dpr_wr_addr(dpr_wr_addr),
    .o_gate_sel(gate_sel), .i_host_req(host_req), .i_host_addr(host_addr),
    .o_host_gnt(host_gnt), .o_busy(busy), .o_load_done(load_done), .o_err(err)
  );

  always #5 sys_clk = ~sys_clk;

  // Behavioural AG: per-gate pass length and address seed.
  int         ag_len [4];
  logic [7:0] ag_seed [4];
  bit         ag_never = 1'b0;
  int         ag_idx = 0;
  logic       ag_done_r = 1'b0;

  function automatic logic [7:0] agf_addr(input logic [7:0] seed, input int i);
    return 8'(int'(seed) + i * 37 + i / 9);
  endfunction
  function automatic logic [2:0] agf_cs(input logic [7:0] seed, input int i);
    return 3'(i / 27 + int'(seed[2:0]));
  endfunction

  always @(posedge sys_clk) begin
    if (!ag_rst_n) begin
      ag_idx    <= 0;
      ag_done_r <= 1'b0;
    end else if (ag_start && !ag_done_r) begin
      if (!ag_never && ag_idx == ag_len[gate_sel] - 1) ag_done_r <= 1'b1;
      ag_idx <= ag_idx + 1;
    end
  end
  assign ag_done = ag_done_r;
  assign ag_addr = agf_addr(ag_seed[gate_sel], ag_idx);
  assign ag_cs   = agf_cs(ag_seed[gate_sel], ag_idx);

  typedef struct packed {
    logic [1:0] g;
    logic [7:0] a;
    logic [2:0] c;
  } wr_t;
  wr_t exp_q[$];
  wr_t mon_e;

  int  checks = 0, failures = 0;
  bit  mon_on = 1'b0;
  bit  host_rand = 1'b0;
  int  n_wr = 0, n_agrst = 0, n_agstart = 0, n_done = 0, n_ldrd = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Expected writes: each masked gate in ascending order, its full AG
  // sequence; a stalled AG yields MAXP reads then the load stops.
  task automatic push_load(input logic [3:0] m, input int limit);
    int n = 0;
    for (int k = 0; k < 4; k++) begin
      if (m[k]) begin
        int len = ag_never ? MAXP : ag_len[k];
        for (int i = 0; i < len; i++) begin
          if (n < limit) begin
            exp_q.push_back('{g: 2'(k), a: agf_addr(ag_seed[k], i), c: agf_cs(ag_seed[k], i)});
            n++;
          end
        end
        if (ag_never) break;
      end
    end
  endtask

  // Monitor: scoreboard for DPR writes plus port-arbitration checks.
  always @(negedge sys_clk) begin
    if (mon_on) begin
      if (dpr_we) begin
        n_wr++;
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {22'd0, gate_sel, dpr_wr_addr}, 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          chk("dpr_write", {20'd0, gate_sel, dpr_wr_addr, dpr_cs}, {20'd0, mon_e});
        end
      end
      if (!ag_rst_n) n_agrst++;
      if (ag_start) n_agstart++;
      if (load_done) n_done++;
      if (buff_rd_en && !host_gnt) n_ldrd++;
      chk("host_gnt", host_gnt, host_req && (!busy || err));
      if (host_gnt) chk("host_port", {buff_rd_en, buff_rd_addr}, {1'b1, host_addr});
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
    if (host_rand) begin
      host_req  = 1'($urandom_range(0, 1));
      host_addr = 8'($urandom);
    end
  endtask

  task automatic issue(input logic [3:0] m, input int limit);
    int t = 0;
    while (!cmd_ready && t < 1000) begin tick(); t++; end
    chk("cmd_ready_before_issue", cmd_ready, 1);
    push_load(m, limit);
    cmd_valid = 1'b1;
    cmd_gate_mask = m;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int t = 0;
    while (!load_done && t < budget) begin tick(); t++; end
    chk(name, load_done, 1);
  endtask

  task automatic seed_gates(input int len);
    for (int k = 0; k < 4; k++) begin
      ag_len[k]  = (len > 0) ? len : int'($urandom_range(1, 30));
      ag_seed[k] = 8'($urandom);
    end
  endtask

  int w0, d0, r0, s0, l0, t;

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_gate_mask = '0; abort = 1'b0;
    host_req = 1'b0; host_addr = '0;
    seed_gates(108);
    tick(); tick();
    chk("rst_status", {cmd_ready, busy, load_done, err, host_gnt}, 5'b10000);
    chk("rst_ag", {ag_rst_n, ag_start, gate_sel}, 4'b1000);
    chk("rst_ports", {buff_rd_en, buff_rd_addr, dpr_we, dpr_cs, dpr_wr_addr}, 21'd0);
    reset_n = 1'b1;
    mon_on = 1'b1;
    tick();

    // Single gate, 108-read pass.
    w0 = n_wr; d0 = n_done; s0 = n_agstart;
    issue(4'b0001, 1 << 30);
    wait_done(400, "A_load_done");
    repeat (3) tick();
    chk("A_writes", n_wr - w0, 108);
    chk("A_run_cycles", n_agstart - s0, 109);
    chk("A_done_count", n_done - d0, 1);
    chk("A_cmd_ready", cmd_ready, 1);
    chk("A_queue_empty", exp_q.size(), 0);

    // Two gates, 1 then 3.
    seed_gates(108);
    w0 = n_wr; d0 = n_done; r0 = n_agrst;
    issue(4'b1010, 1 << 30);
    wait_done(600, "B_load_done");
    repeat (3) tick();
    chk("B_writes", n_wr - w0, 216);
    chk("B_ag_rst_low", n_agrst - r0, 2);
    chk("B_done_count", n_done - d0, 1);
    chk("B_queue_empty", exp_q.size(), 0);

    // Empty mask: done two cycles after acceptance, no AG activity.
    s0 = n_agstart; l0 = n_ldrd;
    issue(4'b0000, 1 << 30);
    chk("C_t1", {busy, load_done}, 2'b10);
    tick();
    chk("C_t2", {busy, load_done}, 2'b01);
    tick();
    chk("C_no_ag_start", n_agstart - s0, 0);
    chk("C_no_reads", n_ldrd - l0, 0);

    // Host held across a four-gate load.
    seed_gates(0);
    host_req = 1'b1; host_addr = 8'($urandom);
    issue(4'b1111, 1 << 30);
    wait_done(800, "D_load_done");
    chk("D_first_idle_gnt", {host_gnt, buff_rd_en, buff_rd_addr}, {2'b11, host_addr});
    tick();
    chk("D_no_host_write", dpr_we, 0);
    host_req = 1'b0;
    chk("D_queue_empty", exp_q.size(), 0);

    // AG never finishes: timeout into ERR, then abort.
    seed_gates(20);
    ag_never = 1'b1;
    s0 = n_agstart; d0 = n_done;
    issue(4'b0100, 1 << 30);
    t = 0;
    while (!err && t < 400) begin tick(); t++; end
    chk("E_err_set", err, 1);
    chk("E_run_cycles", n_agstart - s0, MAXP);
    chk("E_err_state", {busy, ag_rst_n, ag_start}, 3'b100);
    host_req = 1'b1; host_addr = 8'($urandom);
    #1;
    chk("E_host_gnt", {host_gnt, buff_rd_addr}, {1'b1, host_addr});
    repeat (3) tick();
    chk("E_held", {err, ag_rst_n}, 2'b10);
    chk("E_queue_empty", exp_q.size(), 0);
    abort = 1'b1;
    tick();
    abort = 1'b0; host_req = 1'b0;
    chk("E_after_abort", {busy, err, ag_rst_n, load_done}, 4'b0000);
    tick();
    chk("E_ag_rst_release", ag_rst_n, 1);
    chk("E_no_done", n_done - d0, 0);
    ag_never = 1'b0;

    // Abort at RUN cycle 50.
    seed_gates(108);
    d0 = n_done;
    issue(4'b0100, 50);
    t = 0;
    while (!ag_start && t < 20) begin tick(); t++; end
    chk("F_run_start", ag_start, 1);
    repeat (50) tick();
    r0 = n_agrst;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    w0 = n_wr;
    chk("F_after_abort", {busy, ag_rst_n, dpr_we}, 3'b000);
    repeat (3) tick();
    chk("F_no_late_writes", n_wr - w0, 0);
    chk("F_ag_rst_one", n_agrst - r0, 1);
    chk("F_no_done", n_done - d0, 0);
    chk("F_queue_empty", exp_q.size(), 0);
    ag_len[0] = 4;
    issue(4'b0001, 1 << 30);
    wait_done(50, "F_new_cmd_done");
    repeat (2) tick();
    chk("F_new_queue_empty", exp_q.size(), 0);

    // Randomized masks, pass lengths and host traffic.
    host_rand = 1'b1;
    for (int n = 0; n < 8; n++) begin
      seed_gates(0);
      d0 = n_done;
      issue(4'($urandom), 1 << 30);
      wait_done(1000, "R_load_done");
      repeat (2) tick();
      chk("R_queue_empty", exp_q.size(), 0);
      chk("R_done_count", n_done - d0, 1);
    end
    host_rand = 1'b0;
    host_req = 1'b0;
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
